// File: rtl/packet_word_packer.sv
// Byte-to-word packet packer: byte stream (valid/ready/last) in, MSB-first DATA_W words with sop/eop/byte enables out.
// Optional PACKET_LEN_CHECK_EN adds a per-packet length limit (MAX_PKT_BYTES) and the err_oversize output.
module packet_word_packer #(
  parameter int DATA_W        = 64,
  parameter int MAX_PKT_BYTES = 9216
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_byte_enable,
  output logic                out_sop,
  output logic                out_eop
`ifdef PACKET_LEN_CHECK_EN
  ,
  output logic                err_oversize
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  if ((DATA_W % 8) != 0 || DATA_W < 16 || MAX_PKT_BYTES < 1) begin : g_param_err
    $error("packet_word_packer: invalid DATA_W or MAX_PKT_BYTES");
  end

  // Accumulator: builds the current word, and holds a finished one while out is stalled.
  logic              r_init;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_acc_data;
  logic [BYTES-1:0]  r_acc_be;
  logic              r_acc_full;
  logic              r_acc_sop;
  logic              r_acc_eop;
  logic              r_sop_pending;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [BYTES-1:0]  r_out_be;
  logic              r_out_sop;
  logic              r_out_eop;

  logic              w_fire;
  logic              w_write;
  logic              w_last_eff;
  logic              w_complete;
  logic              w_out_free;
  logic              w_load_from_acc;
  logic              w_load_direct;
  logic              w_hold_acc;
  logic              w_clear_out;
  logic              w_force_last;
  logic              w_dropping;
  logic [DATA_W-1:0] w_merge_data;
  logic [BYTES-1:0]  w_merge_be;

  assign in_ready        = r_init && !r_acc_full;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_byte_enable = r_out_be;
  assign out_sop         = r_out_sop;
  assign out_eop         = r_out_eop;

  assign w_fire          = in_valid && in_ready;
  assign w_write         = w_fire && !w_dropping;
  assign w_last_eff      = in_last || w_force_last;
  assign w_complete      = w_write && ((r_idx == IDX_W'(BYTES - 1)) || w_last_eff);
  assign w_out_free      = !r_out_valid || out_ready;
  // acc_full blocks in_ready, so a held word and a completing byte never coincide.
  assign w_load_from_acc = r_acc_full && w_out_free;
  assign w_load_direct   = w_complete && w_out_free;
  assign w_hold_acc      = w_complete && !w_out_free;
  assign w_clear_out     = w_out_free && !w_load_from_acc && !w_load_direct;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_merge_data = r_acc_data;
    w_merge_be   = r_acc_be;
    for (int k = 0; k < BYTES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_merge_data[(BYTES-1-k)*8 +: 8] = in_data;
        w_merge_be[BYTES-1-k]            = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers are
  // small, so they are reset too, which keeps out_* at zero and discards partial words on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init        <= 1'b0;
      r_idx         <= '0;
      r_acc_data    <= '0;
      r_acc_be      <= '0;
      r_acc_full    <= 1'b0;
      r_acc_sop     <= 1'b0;
      r_acc_eop     <= 1'b0;
      r_sop_pending <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_be      <= '0;
      r_out_sop     <= 1'b0;
      r_out_eop     <= 1'b0;
    end else begin
      r_init <= 1'b1;

      if (w_load_from_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_acc_data;
        r_out_be    <= r_acc_be;
        r_out_sop   <= r_acc_sop;
        r_out_eop   <= r_acc_eop;
        r_acc_data  <= '0;
        r_acc_be    <= '0;
        r_acc_full  <= 1'b0;
        r_acc_sop   <= 1'b0;
        r_acc_eop   <= 1'b0;
      end else if (w_load_direct) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_merge_data;
        r_out_be    <= w_merge_be;
        r_out_sop   <= r_sop_pending;
        r_out_eop   <= w_last_eff;
        r_acc_data  <= '0;
        r_acc_be    <= '0;
      end else begin
        if (w_clear_out) begin
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_out_be    <= '0;
          r_out_sop   <= 1'b0;
          r_out_eop   <= 1'b0;
        end
        if (w_hold_acc) begin
          r_acc_data <= w_merge_data;
          r_acc_be   <= w_merge_be;
          r_acc_full <= 1'b1;
          r_acc_sop  <= r_sop_pending;
          r_acc_eop  <= w_last_eff;
        end else if (w_write) begin
          r_acc_data <= w_merge_data;
          r_acc_be   <= w_merge_be;
        end
      end

      if (w_write) begin
        r_idx <= w_complete ? '0 : r_idx + IDX_W'(1);
      end
      if (w_complete) begin
        r_sop_pending <= w_last_eff;
      end
    end
  end

`ifdef PACKET_LEN_CHECK_EN
  localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_drop;
  logic             r_acc_err;
  logic             r_out_err;

  assign w_dropping   = r_drop;
  assign w_force_last = w_fire && !r_drop && !in_last
                        && (r_cnt == CNT_W'(MAX_PKT_BYTES - 1));
  assign err_oversize = r_out_err;

  // After a truncated word, bytes up to and including in_last are accepted and discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_drop    <= 1'b0;
      r_acc_err <= 1'b0;
      r_out_err <= 1'b0;
    end else begin
      if (w_fire) begin
        if (r_drop) begin
          if (in_last) r_drop <= 1'b0;
        end else if (w_last_eff) begin
          r_cnt  <= '0;
          r_drop <= w_force_last;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      if (w_load_from_acc) begin
        r_out_err <= r_acc_err;
        r_acc_err <= 1'b0;
      end else if (w_load_direct) begin
        r_out_err <= w_force_last;
      end else begin
        if (w_clear_out) r_out_err <= 1'b0;
        if (w_hold_acc)  r_acc_err <= w_force_last;
      end
    end
  end
`else
  assign w_dropping   = 1'b0;
  assign w_force_last = 1'b0;
`endif

endmodule

// File: tb/tb_packet_word_packer.sv
// Directed self-checking bench for packet_word_packer (DATA_W = 64); the oversize case runs with PACKET_LEN_CHECK_EN.
module tb_packet_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_byte_enable;
  logic        out_sop;
  logic        out_eop;
  logic        w_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int unstable = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  be;
    logic        sop;
    logic        eop;
    logic        err;
    int          cyc;
  } word_t;

  word_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

`ifdef PACKET_LEN_CHECK_EN
  packet_word_packer #(.DATA_W(64), .MAX_PKT_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_byte_enable(out_byte_enable), .out_sop(out_sop), .out_eop(out_eop),
    .err_oversize(w_err)
  );
`else
  packet_word_packer #(.DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_byte_enable(out_byte_enable), .out_sop(out_sop), .out_eop(out_eop)
  );
  assign w_err = 1'b0;
`endif

  // Inputs change 1 time unit after posedge, so the negedge view is what the next posedge transfers.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic [7:0]  prev_be;
  logic        prev_sop;
  logic        prev_eop;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!out_valid || out_data !== prev_d || out_byte_enable !== prev_be
                         || out_sop !== prev_sop || out_eop !== prev_eop))
        unstable++;
      if (out_valid && out_ready)
        q.push_back('{out_data, out_byte_enable, out_sop, out_eop, w_err, cyc});
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_be    = out_byte_enable;
      prev_sop   = out_sop;
      prev_eop   = out_eop;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] first, input int n, input bit last);
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = first + 8'(i);
      in_last  = last && (i == n - 1);
      guard    = 0;
      acc      = 1'b0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic expect_word(input string tag, input logic [63:0] d, input logic [7:0] be,
                             input logic sop, input logic eop, input logic err);
    word_t w;
    if (q.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
      return;
    end
    w = q.pop_front();
    check({tag, "_data"}, w.d, d);
    check({tag, "_be"},   64'(w.be), 64'(be));
    check({tag, "_sop"},  64'(w.sop), 64'(sop));
    check({tag, "_eop"},  64'(w.eop), 64'(eop));
    check({tag, "_err"},  64'(w.err), 64'(err));
  endtask

  initial begin
    word_t w0;
    word_t w1;
    int    c0;
    logic [63:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    step(3);
    check("rst_in_ready",  64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    check("rst_out_be",    64'(out_byte_enable), 64'd0);
    check("rst_out_sopeop", 64'({out_sop, out_eop, w_err}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("pre_init_in_ready", 64'(in_ready), 64'd0);
    step(1);
    check("init_in_ready", 64'(in_ready), 64'd1);

    // 1: two full words at 1 byte/cycle
    c0 = cyc;
    send(8'h00, 16, 1'b1);
    check("t1_rate", 64'(cyc - c0), 64'd16);
    step(3);
    check("t1_count", 64'(q.size()), 64'd2);
    expect_word("t1_w0", 64'h0001020304050607, 8'hFF, 1'b1, 1'b0, 1'b0);
    expect_word("t1_w1", 64'h08090A0B0C0D0E0F, 8'hFF, 1'b0, 1'b1, 1'b0);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_out_data",  out_data, 64'd0);
    check("idle_out_be",    64'(out_byte_enable), 64'd0);

    // 2: short last word
    send(8'hA0, 11, 1'b1);
    step(3);
    check("t2_count", 64'(q.size()), 64'd2);
    expect_word("t2_w0", 64'hA0A1A2A3A4A5A6A7, 8'hFF, 1'b1, 1'b0, 1'b0);
    expect_word("t2_w1", 64'hA8A9AA0000000000, 8'hE0, 1'b0, 1'b1, 1'b0);

    // 3: single-byte packet, visible one cycle after the accepting edge
    send(8'h5A, 1, 1'b1);
    check("t3_lat_valid", 64'(out_valid), 64'd1);
    check("t3_lat_data",  out_data, 64'h5A00000000000000);
    step(2);
    check("t3_count", 64'(q.size()), 64'd1);
    expect_word("t3_w0", 64'h5A00000000000000, 8'h80, 1'b1, 1'b1, 1'b0);

    // 4: backpressure for 20 cycles on a 24-byte packet
    out_ready = 1'b0;
    send(8'h40, 16, 1'b0);
    check("t4_in_ready_low", 64'(in_ready), 64'd0);
    check("t4_held_valid",   64'(out_valid), 64'd1);
    held = out_data;
    check("t4_held_data",    held, 64'h4041424344454647);
    check("t4_held_sop",     64'({out_sop, out_eop}), 64'b10);
    step(4);
    check("t4_still_held",   out_data, 64'h4041424344454647);
    check("t4_in_ready_still_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(8'h50, 8, 1'b1);
    step(4);
    check("t4_stable", 64'(unstable), 64'd0);
    check("t4_count",  64'(q.size()), 64'd3);
    if (q.size() >= 2) begin
      w0 = q[0];
      w1 = q[1];
      check("t4_no_bubble", 64'(w1.cyc - w0.cyc), 64'd1);
    end
    expect_word("t4_w0", 64'h4041424344454647, 8'hFF, 1'b1, 1'b0, 1'b0);
    expect_word("t4_w1", 64'h48494A4B4C4D4E4F, 8'hFF, 1'b0, 1'b0, 1'b0);
    expect_word("t4_w2", 64'h5051525354555657, 8'hFF, 1'b0, 1'b1, 1'b0);

    // 5: reset mid-packet discards partial data
    send(8'h20, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready",  64'(in_ready), 64'd0);
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    step(1);
    rst_n = 1'b1;
    q.delete();
    step(1);
    send(8'h11, 3, 1'b1);
    step(3);
    check("t5_count", 64'(q.size()), 64'd1);
    expect_word("t5_w0", 64'h1112130000000000, 8'hE0, 1'b1, 1'b1, 1'b0);

    // 7: exactly one full word with last
    send(8'hC0, 8, 1'b1);
    step(3);
    check("t7_count", 64'(q.size()), 64'd1);
    expect_word("t7_w0", 64'hC0C1C2C3C4C5C6C7, 8'hFF, 1'b1, 1'b1, 1'b0);

`ifdef PACKET_LEN_CHECK_EN
    // 6: 20-byte packet against a 16-byte limit, then a normal packet
    send(8'h00, 20, 1'b1);
    step(3);
    check("t6_count", 64'(q.size()), 64'd2);
    expect_word("t6_w0", 64'h0001020304050607, 8'hFF, 1'b1, 1'b0, 1'b0);
    expect_word("t6_w1", 64'h08090A0B0C0D0E0F, 8'hFF, 1'b0, 1'b1, 1'b1);
    check("t6_err_cleared", 64'(w_err), 64'd0);
    send(8'h30, 8, 1'b1);
    step(3);
    check("t6_next_count", 64'(q.size()), 64'd1);
    expect_word("t6_next", 64'h3031323334353637, 8'hFF, 1'b1, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
